operand_ctrl_fsm: RTL and testbench

Multicycle control unit that fetches and decodes each 32-bit instruction. It drives the ALU operand-A select code, the operand-B select code and the ALU operation. It also produces the two immediates consumed by the operand-A mux: the sign-extended immediate and the sign-extended immediate shifted left by 2. It sits between instruction/data memory handshakes and the datapath (register file, PC, ALU, operand muxes).

---
 rtl/operand_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 tb/tb_operand_ctrl_fsm.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_ctrl_fsm.sv
// Multicycle fetch/decode control FSM driving ALU operand selects, ALU op and memory/PC/regfile strobes.
// Optional build macro OPERAND_CTRL_TRAP_EN: illegal instructions lock the FSM in TRAP until reset.
module operand_ctrl_fsm #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_data,
    input  logic              mem_ack,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              alu_zero,
    output logic [1:0]        sel_operA,
    output logic [1:0]        sel_operB,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] immediate_ext,
    output logic [DATA_W-1:0] immediate_desp,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              tgt_write,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
`ifdef OPERAND_CTRL_TRAP_EN
        , ST_TRAP = 3'd5
`endif
    } state_t;

    typedef enum logic [2:0] {
        K_R    = 3'd0,
        K_ADDI = 3'd1,
        K_LW   = 3'd2,
        K_SW   = 3'd3,
        K_BEQ  = 3'd4,
        K_J    = 3'd5,
        K_ILL  = 3'd6
    } kind_t;

    function automatic kind_t decode_kind(input logic [5:0] opcode, input logic [5:0] funct);
        kind_t k;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: k = K_R;
                    default:                           k = K_ILL;
                endcase
            end
            6'h08:   k = K_ADDI;
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            6'h02:   k = K_J;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] funct);
        logic [3:0] op;
        case (funct)
            6'h22:   op = ALU_SUB;
            6'h24:   op = ALU_AND;
            6'h25:   op = ALU_OR;
            6'h2A:   op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [DATA_W-1:0]  ir_r;
    logic [CNT_W-1:0]   tmo_cnt_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               mem_err_r;
    logic               ir_load_s;
    logic               tmo_hit_s;
    kind_t              kind_s;
    logic [DATA_W-1:0]  imm_ext_s;
    logic               ir_unused_s;

    assign kind_s      = decode_kind(ir_r[31:26], ir_r[5:0]);
    assign cnt_inc_s   = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign tmo_hit_s   = (state_r == ST_MEM) && !mem_ack && (cnt_inc_s == CNT_W'(MEM_TIMEOUT));
    assign imm_ext_s   = {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
    assign ir_unused_s = ^ir_r[25:16];

    // Immediates are pure functions of IR, forced low while reset is asserted.
    assign immediate_ext  = rst_n ? imm_ext_s : {DATA_W{1'b0}};
    assign immediate_desp = rst_n ? {imm_ext_s[DATA_W-3:0], 2'b00} : {DATA_W{1'b0}};

    // State, instruction register, MEM timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            ir_r      <= {DATA_W{1'b0}};
            tmo_cnt_r <= {CNT_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (ir_load_s) begin
                ir_r <= instr_data;
            end
            if (state_r == ST_MEM && !mem_ack && !tmo_hit_s) begin
                tmo_cnt_r <= cnt_inc_s;
            end else begin
                tmo_cnt_r <= {CNT_W{1'b0}};
            end
            if (tmo_hit_s) begin
                mem_err_r <= 1'b1;
            end
        end
    end

    // Next-state and output decode; everything stays zero while reset is held.
    always_comb begin
        state_nxt_s = state_r;
        ir_load_s   = 1'b0;
        instr_req   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        sel_operA   = 2'b00;
        sel_operB   = 2'b00;
        alu_op      = ALU_ADD;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        tgt_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;
        mem_err     = 1'b0;
        if (!rst_n) begin
            state_nxt_s = ST_FETCH;
        end else begin
            mem_err = mem_err_r;
            case (state_r)
                ST_FETCH: begin
                    instr_req = 1'b1;
                    sel_operA = 2'b01;
                    sel_operB = 2'b01;
                    if (instr_valid) begin
                        ir_load_s   = 1'b1;
                        pc_write    = 1'b1;
                        state_nxt_s = ST_DECODE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    sel_operA   = 2'b11;
                    sel_operB   = 2'b01;
                    tgt_write   = 1'b1;
                    state_nxt_s = ST_EXEC;
                end
                ST_EXEC: begin
                    case (kind_s)
                        K_R: begin
                            alu_op      = funct_alu(ir_r[5:0]);
                            state_nxt_s = ST_WB;
                        end
                        K_ADDI: begin
                            sel_operA   = 2'b10;
                            sel_operB   = 2'b10;
                            state_nxt_s = ST_WB;
                        end
                        K_LW, K_SW: begin
                            sel_operA   = 2'b10;
                            sel_operB   = 2'b10;
                            state_nxt_s = ST_MEM;
                        end
                        K_BEQ: begin
                            alu_op      = ALU_SUB;
                            pc_src      = 2'b01;
                            pc_write    = alu_zero;
                            state_nxt_s = ST_FETCH;
                        end
                        K_J: begin
                            pc_src      = 2'b10;
                            pc_write    = 1'b1;
                            state_nxt_s = ST_FETCH;
                        end
                        default: begin
                            illegal = 1'b1;
`ifdef OPERAND_CTRL_TRAP_EN
                            state_nxt_s = ST_TRAP;
`else
                            state_nxt_s = ST_FETCH;
`endif
                        end
                    endcase
                end
                ST_MEM: begin
                    // Address operands stay selected while the access is outstanding.
                    sel_operA = 2'b10;
                    sel_operB = 2'b10;
                    mem_read  = (kind_s == K_LW);
                    mem_write = (kind_s == K_SW);
                    if (mem_ack) begin
                        state_nxt_s = (kind_s == K_LW) ? ST_WB : ST_FETCH;
                    end else if (tmo_hit_s) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_write   = 1'b1;
                    reg_dst     = (kind_s == K_R);
                    mem_to_reg  = (kind_s == K_LW);
                    state_nxt_s = ST_FETCH;
                end
`ifdef OPERAND_CTRL_TRAP_EN
                ST_TRAP: begin
                    illegal     = 1'b1;
                    state_nxt_s = ST_TRAP;
                end
`endif
                default: begin
                    state_nxt_s = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_ctrl_fsm.sv
// Scoreboard bench for operand_ctrl_fsm: a per-instruction reference model queues the expected
// output vector of every cycle; a negedge monitor pops and compares against the DUT.
module tb_operand_ctrl_fsm;

    localparam int TMO = 16;
    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, instr_valid, mem_ack, mem_read, mem_write, alu_zero;
    logic [31:0] instr_data, immediate_ext, immediate_desp;
    logic [1:0]  sel_operA, sel_operB, pc_src;
    logic [3:0]  alu_op;
    logic        pc_write, tgt_write, reg_write, reg_dst, mem_to_reg, illegal, mem_err;

    always #5 clk = ~clk;

    operand_ctrl_fsm #(.DATA_W(32), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr_req(instr_req), .instr_valid(instr_valid),
        .instr_data(instr_data), .mem_ack(mem_ack), .mem_read(mem_read), .mem_write(mem_write),
        .alu_zero(alu_zero), .sel_operA(sel_operA), .sel_operB(sel_operB), .alu_op(alu_op),
        .immediate_ext(immediate_ext), .immediate_desp(immediate_desp), .pc_write(pc_write),
        .pc_src(pc_src), .tgt_write(tgt_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .mem_err(mem_err)
    );

    typedef struct packed {
        logic        instr_req;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [3:0]  alu_op;
        logic [31:0] imm_ext;
        logic [31:0] imm_desp;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic        tgt_write;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        illegal;
        logic        mem_err;
    } obs_t;

    obs_t  act_s;
    obs_t  exp_q[$];
    obs_t  msk_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    logic [31:0] m_ir;
    logic        m_err;

    assign act_s = {instr_req, mem_read, mem_write, sel_operA, sel_operB, alu_op, immediate_ext,
                    immediate_desp, pc_write, pc_src, tgt_write, reg_write, reg_dst, mem_to_reg,
                    illegal, mem_err};

    obs_t  mon_e, mon_m;
    string mon_t;

    // Monitor: one expected vector per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_m = msk_q.pop_front();
            mon_t = tag_q.pop_front();
            checks++;
            if (((act_s ^ mon_e) & mon_m) != '0) begin
                failures++;
                $display("FAIL %s at %0t: actual=%h required=%h care=%h", mon_t, $time, act_s, mon_e, mon_m);
            end
        end
    end

    function automatic obs_t base_rec(input logic [31:0] ir, input logic err);
        obs_t e;
        logic signed [15:0] h;
        int v;
        e = '0;
        h = ir[15:0];
        v = h;
        e.imm_ext  = v;
        e.imm_desp = v * 4;
        e.mem_err  = err;
        return e;
    endfunction

    function automatic int kind_of(input logic [31:0] w, output logic [3:0] aop);
        aop = 4'd0;
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20:   begin aop = 4'd0; return K_R; end
                    6'h22:   begin aop = 4'd1; return K_R; end
                    6'h24:   begin aop = 4'd2; return K_R; end
                    6'h25:   begin aop = 4'd3; return K_R; end
                    6'h2A:   begin aop = 4'd4; return K_R; end
                    default: return K_ILL;
                endcase
            end
            6'h08:   return K_ADDI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    task automatic cyc(input obs_t e, input obs_t m, input string tag);
        exp_q.push_back(e);
        msk_q.push_back(m);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_idle();
        instr_valid = 1'($urandom);
        instr_data  = $urandom;
        mem_ack     = 1'($urandom);
        alu_zero    = 1'($urandom);
    endtask

    task automatic do_reset(input int n);
        obs_t full;
        full = '1;
        for (int i = 0; i < n; i++) begin
            rand_idle();
            rst_n = 1'b0;
            cyc('0, full, "reset");
        end
        rst_n = 1'b1;
        m_ir  = 32'd0;
        m_err = 1'b0;
    endtask

    task automatic t_fetch(input logic [31:0] w, input int fwait);
        obs_t e, full;
        full = '1;
        for (int i = 0; i < fwait; i++) begin
            rand_idle();
            instr_valid = 1'b0;
            e = base_rec(m_ir, m_err);
            e.instr_req = 1'b1; e.sel_a = 2'b01; e.sel_b = 2'b01;
            cyc(e, full, "fetch_wait");
        end
        rand_idle();
        instr_valid = 1'b1;
        instr_data  = w;
        e = base_rec(m_ir, m_err);
        e.instr_req = 1'b1; e.sel_a = 2'b01; e.sel_b = 2'b01; e.pc_write = 1'b1;
        cyc(e, full, "fetch");
        m_ir = w;
        rand_idle();
        e = base_rec(m_ir, m_err);
        e.sel_a = 2'b11; e.sel_b = 2'b01; e.tgt_write = 1'b1;
        cyc(e, full, "decode");
    endtask

    // Full instruction: ackd = MEM cycles before mem_ack (>= TMO means never acknowledged).
    task automatic run_instr(input logic [31:0] w, input int fwait, input int ackd, input logic zero,
                             input bit abort_in_mem);
        obs_t e, full, mmask;
        logic [3:0] aop;
        int k;
        bit acked;
        full  = '1;
        mmask = '1;
        mmask.sel_a = 2'b00; mmask.sel_b = 2'b00; mmask.alu_op = 4'd0;
        k = kind_of(w, aop);
        t_fetch(w, fwait);
        rand_idle();
        e = base_rec(m_ir, m_err);
        case (k)
            K_R:                begin e.alu_op = aop; end
            K_ADDI, K_LW, K_SW: begin e.sel_a = 2'b10; e.sel_b = 2'b10; end
            K_BEQ: begin
                alu_zero = zero;
                e.alu_op = 4'd1; e.pc_src = 2'b01; e.pc_write = zero;
            end
            K_J:     begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
            default: begin e.illegal = 1'b1; end
        endcase
        cyc(e, full, "exec");
        acked = 1'b0;
        if (k == K_LW || k == K_SW) begin
            for (int c = 0; c < TMO && !acked; c++) begin
                rand_idle();
                mem_ack = (c == ackd);
                e = base_rec(m_ir, m_err);
                e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                cyc(e, mmask, "mem");
                if (c == ackd) begin
                    acked = 1'b1;
                end
                if (abort_in_mem && c == 1) begin
                    do_reset(2);
                    return;
                end
            end
            if (!acked) begin
                m_err = 1'b1;
            end
        end
        if (k == K_R || k == K_ADDI || (k == K_LW && acked)) begin
            rand_idle();
            e = base_rec(m_ir, m_err);
            e.reg_write = 1'b1; e.reg_dst = (k == K_R); e.mem_to_reg = (k == K_LW);
            cyc(e, full, "wb");
        end
`ifdef OPERAND_CTRL_TRAP_EN
        if (k == K_ILL) begin
            for (int i = 0; i < 4; i++) begin
                rand_idle();
                e = base_rec(m_ir, m_err);
                e.illegal = 1'b1;
                cyc(e, full, "trap");
            end
            do_reset(2);
        end
`endif
    endtask

    function automatic logic [31:0] rand_word(input int pick);
        logic [31:0] w;
        logic [5:0]  functs [5];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        w = $urandom;
        case (pick)
            0:       begin w[31:26] = 6'h00; w[5:0] = functs[$urandom_range(0, 4)]; end
            1:       begin w[31:26] = 6'h00; end
            2:       begin w[31:26] = 6'h08; end
            3:       begin w[31:26] = 6'h23; end
            4:       begin w[31:26] = 6'h2B; end
            5:       begin w[31:26] = 6'h04; end
            6:       begin w[31:26] = 6'h02; end
            default: begin end
        endcase
        return w;
    endfunction

    initial begin
        obs_t e;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 32'd0;
        mem_ack     = 1'b0;
        alu_zero    = 1'b0;
        m_ir        = 32'd0;
        m_err       = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Directed cases
        run_instr(32'h012A4020, 0, 0, 1'b0, 1'b0);          // add
        run_instr(32'h2128FFFC, 1, 0, 1'b0, 1'b0);          // addi, negative imm
        run_instr(32'h11090003, 0, 0, 1'b1, 1'b0);          // beq taken
        run_instr(32'h11090003, 2, 0, 1'b0, 1'b0);          // beq not taken
        run_instr(32'h8D280004, 0, 3, 1'b0, 1'b0);          // lw, ack after 3 cycles
        run_instr(32'hAD280008, 0, 0, 1'b0, 1'b0);          // sw, immediate ack
        run_instr(32'h08000010, 0, 0, 1'b0, 1'b0);          // j
        run_instr(32'hFC000000, 0, 0, 1'b0, 1'b0);          // opcode 0x3F
        run_instr(32'h012A4021, 0, 0, 1'b0, 1'b0);          // R-type with bad funct
        run_instr(32'h8D287FFC, 0, TMO + 5, 1'b0, 1'b0);    // lw timeout
        run_instr(32'h012A402A, 0, 0, 1'b0, 1'b0);          // slt, mem_err sticky
        run_instr(32'hAD280008, 0, TMO + 5, 1'b0, 1'b1);    // reset during sw MEM
        rand_idle();
        instr_valid = 1'b0;
        e = base_rec(32'd0, 1'b0);
        e.instr_req = 1'b1; e.sel_a = 2'b01; e.sel_b = 2'b01;
        cyc(e, '1, "post_reset_fetch");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            int pick, ack;
            pick = $urandom_range(0, 8);
            ack  = $urandom_range(0, 20);
            run_instr(rand_word(pick), $urandom_range(0, 3), ack, 1'($urandom), 1'b0);
            if (n % 25 == 24) begin
                do_reset($urandom_range(1, 2));
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
